// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_fs.sv
// Single-bit full subtractor cell: diff = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial N-bit subtractor: one full_subtractor cell is reused LSB first over WIDTH cycles,
// sequenced by an IDLE/SHIFT/DONE FSM with a start/done handshake.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // d_sh keeps only the WIDTH-1 bits already produced; the current cell output completes the word.
  localparam int DW    = (WIDTH > 1) ? WIDTH - 1 : 1;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [DW-1:0]      d_sh;
  logic [DW-1:0]      d_sh_next;
  logic [WIDTH-1:0]   res_next;
  logic [CNT_W-1:0]   cnt;
  logic               br;
  logic               cell_d;
  logic               cell_bout;
  logic               last;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (cell_d),
    .bout (cell_bout)
  );

  generate
    if (WIDTH > 1) begin : g_wide
      assign res_next  = {cell_d, d_sh};
      assign d_sh_next = res_next[WIDTH-1:1];
    end else begin : g_one
      assign res_next  = cell_d;
      assign d_sh_next = cell_d;
    end
  endgenerate

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_SHIFT;
        else       state_next = S_IDLE;
      end
      S_SHIFT: begin
        if (last) state_next = S_DONE;
        else      state_next = S_SHIFT;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: operand load on accept, one bit per SHIFT cycle, result capture on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= {WIDTH{1'b0}};
      b_sh       <= {WIDTH{1'b0}};
      d_sh       <= {DW{1'b0}};
      br         <= 1'b0;
      cnt        <= {CNT_W{1'b0}};
      diff       <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= borrow_in;
            cnt  <= {CNT_W{1'b0}};
          end
        end
        S_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_sh_next;
          br   <= cell_bout;
          if (last) begin
            diff       <= res_next;
            borrow_out <= cell_bout;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          br <= br;
        end
      endcase
    end
  end

endmodule
